bin_to_bcd_seq: RTL

//  Parametrised, handshaked binary-to-BCD converter using sequential double-dabble
//  (shift-and-add-3), one bit per clock. It replaces the fixed 32-bit free-running

---
 rtl/bcd_pkg.sv | 43 ++++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helpers for the binary-to-BCD converter
package bcd_pkg;

    // Bits per packed BCD digit
    localparam int DIGIT_W = 4;

    // Converter control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Ceiling log2, at least 1, so a counter holding n-1 is never zero bits wide
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    // Decimal digits needed to print the largest unsigned value of bin_w bits
    function automatic int min_digits(input int bin_w);
        logic [63:0] m;
        int          d;
        if (bin_w >= 64) begin
            m = '1;
        end else begin
            m = (64'd1 << bin_w) - 64'd1;
        end
        d = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 to any digit of 5 or more
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // A digit >= 5 would become >= 10 after the next shift; pre-add 3 so the shift carries
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= DIGIT_W'(5)) begin
            digit_o = digit_i + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - handshaked sequential double-dabble binary-to-BCD converter
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [BIN_W-1:0]          bin_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic [DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                      neg_o,
    output logic                      ovf_o
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = clog2(BIN_W + 1);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [BIN_W-1:0]   mag_q,     mag_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;
    logic               sign_q,    sign_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]   bcd_q,     bcd_d;
    logic               neg_q,     neg_d;
    logic               ovf_q,     ovf_d;
    logic               done_q,    done_d;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] shifted;
    logic [ACC_W-1:0]       acc_next;
    logic [BIN_W-1:0]       mag_next;
    logic                   carry_out;
    logic                   bin_neg;
    logic [BIN_W-1:0]       bin_mag;

    // One correction cell per digit of the accumulator
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The corrected accumulator and the magnitude shift left together as one register
    assign shifted   = {acc_adj, mag_q} << 1;
    assign acc_next  = shifted[ACC_W+BIN_W-1:BIN_W];
    assign mag_next  = shifted[BIN_W-1:0];
    // A bit falling off the top digit means the value no longer fits in DIGITS digits
    assign carry_out = acc_adj[ACC_W-1];

    // Most-negative input negates to itself, which read as unsigned is the right magnitude
    assign bin_neg = (SIGNED != 0) && bin_i[BIN_W-1];
    assign bin_mag = bin_neg ? ((~bin_i) + BIN_W'(1)) : bin_i;

    // Next-state logic: load on accepted start, one double-dabble step per SHIFT cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mag_d     = bin_mag;
                    sign_d    = bin_neg;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                acc_d     = acc_next;
                mag_d     = mag_next;
                ovf_acc_d = ovf_acc_q | carry_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = acc_next;
                    neg_d   = sign_q;
                    ovf_d   = ovf_acc_q | carry_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset also aborts a conversion in flight without a done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign done_o  = done_q;
    assign bcd_o   = bcd_q;
    assign neg_o   = neg_q;
    assign ovf_o   = ovf_q;

endmodule
